traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/phase_timer.sv | 39 +++
 rtl/traffic_phase_scheduler.sv | 123 ++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase codes, round-robin pointer values and default dwell lengths
// for the traffic phase scheduler.
package traffic_pkg;

    localparam logic [2:0] PH_MAIN_GREEN  = 3'd0;
    localparam logic [2:0] PH_MAIN_YELLOW = 3'd1;
    localparam logic [2:0] PH_ALL_RED     = 3'd2;
    localparam logic [2:0] PH_DECIDE      = 3'd3;
    localparam logic [2:0] PH_SIDE_GREEN  = 3'd4;
    localparam logic [2:0] PH_SIDE_YELLOW = 3'd5;
    localparam logic [2:0] PH_TURN_GREEN  = 3'd6;
    localparam logic [2:0] PH_TURN_YELLOW = 3'd7;

    localparam logic RR_V = 1'b0;
    localparam logic RR_Z = 1'b1;

    localparam int DEF_MAIN_GREEN_MIN = 8;
    localparam int DEF_SIDE_GREEN     = 6;
    localparam int DEF_TURN_GREEN     = 4;
    localparam int DEF_YELLOW         = 3;
    localparam int DEF_ALL_RED        = 1;
    localparam int DEF_TW             = 8;

endpackage

// File: rtl/phase_timer.sv
// Down-counter holding the remaining ticks (minus one) of the current phase;
// a load always beats a tick, and the count parks at zero.
module phase_timer #(
    parameter int             TW        = 8,
    parameter logic [TW-1:0]  RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    output logic [TW-1:0] count,
    output logic          expire
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - {{(TW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign expire = tick && (count_q == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Phase FSM and request arbitration for a main road with a side road (V)
// and a turn lane (Z); dwell timing is delegated to phase_timer.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MAIN_GREEN_MIN = DEF_MAIN_GREEN_MIN,
    parameter int SIDE_GREEN     = DEF_SIDE_GREEN,
    parameter int TURN_GREEN     = DEF_TURN_GREEN,
    parameter int YELLOW         = DEF_YELLOW,
    parameter int ALL_RED        = DEF_ALL_RED,
    parameter int TW             = DEF_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          req_v,
    input  logic          req_z,
    output logic [2:0]    phase,
    output logic          phase_change,
    output logic [1:0]    pending,
    output logic [TW-1:0] ticks_left
);

    logic [2:0]    phase_q, phase_d;
    logic [1:0]    pending_q, pending_d;
    logic          rr_q, rr_d;
    logic          phase_change_q, phase_change_d;
    logic          expire;
    logic [TW-1:0] load_val;

    function automatic logic [TW-1:0] reload_for(input logic [2:0] p);
        logic [TW-1:0] r;
        case (p)
            PH_MAIN_GREEN:                                 r = TW'(MAIN_GREEN_MIN - 1);
            PH_MAIN_YELLOW, PH_SIDE_YELLOW, PH_TURN_YELLOW: r = TW'(YELLOW - 1);
            PH_ALL_RED, PH_DECIDE:                         r = TW'(ALL_RED - 1);
            PH_SIDE_GREEN:                                 r = TW'(SIDE_GREEN - 1);
            PH_TURN_GREEN:                                 r = TW'(TURN_GREEN - 1);
            default:                                       r = TW'(MAIN_GREEN_MIN - 1);
        endcase
        return r;
    endfunction

    always_comb begin
        phase_d   = phase_q;
        pending_d = pending_q;
        rr_d      = rr_q;

        // A requester's own green/yellow ignores its sensor, so a held sensor re-arms after yellow.
        if (req_v && (phase_q != PH_SIDE_GREEN) && (phase_q != PH_SIDE_YELLOW)) begin
            pending_d[0] = 1'b1;
        end
        if (req_z && (phase_q != PH_TURN_GREEN) && (phase_q != PH_TURN_YELLOW)) begin
            pending_d[1] = 1'b1;
        end

        case (phase_q)
            PH_MAIN_GREEN:  if (expire && (pending_q != 2'b00)) phase_d = PH_MAIN_YELLOW;
            PH_MAIN_YELLOW: if (expire) phase_d = PH_ALL_RED;
            PH_ALL_RED:     if (expire) phase_d = PH_DECIDE;
            PH_DECIDE: begin
                if (expire) begin
                    if (pending_q[0] && (!pending_q[1] || (rr_q == RR_V))) begin
                        phase_d = PH_SIDE_GREEN;
                    end else if (pending_q[1]) begin
                        phase_d = PH_TURN_GREEN;
                    end else begin
                        phase_d = PH_MAIN_GREEN;
                    end
                end
            end
            PH_SIDE_GREEN:  if (expire) phase_d = PH_SIDE_YELLOW;
            PH_TURN_GREEN:  if (expire) phase_d = PH_TURN_YELLOW;
            PH_SIDE_YELLOW, PH_TURN_YELLOW: if (expire) phase_d = PH_MAIN_GREEN;
            default:        phase_d = PH_MAIN_GREEN;
        endcase

        // Entering a green clears its request (beating any same-cycle set) and hands priority away.
        if ((phase_d == PH_SIDE_GREEN) && (phase_q != PH_SIDE_GREEN)) begin
            pending_d[0] = 1'b0;
            rr_d         = RR_Z;
        end
        if ((phase_d == PH_TURN_GREEN) && (phase_q != PH_TURN_GREEN)) begin
            pending_d[1] = 1'b0;
            rr_d         = RR_V;
        end

        phase_change_d = (phase_d != phase_q);
        load_val       = reload_for(phase_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q        <= PH_MAIN_GREEN;
            pending_q      <= 2'b00;
            rr_q           <= RR_V;
            phase_change_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            pending_q      <= pending_d;
            rr_q           <= rr_d;
            phase_change_q <= phase_change_d;
        end
    end

    phase_timer #(
        .TW        (TW),
        .RESET_VAL (TW'(MAIN_GREEN_MIN - 1))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (phase_change_d),
        .load_val (load_val),
        .tick     (tick),
        .count    (ticks_left),
        .expire   (expire)
    );

    assign phase        = phase_q;
    assign phase_change = phase_change_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench: default-parameter scheduler driven by hand-placed ticks and
// requests, plus a 2/2/2/1/1 instance run with tick held high.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset, tick, req_v, req_z;
    logic [2:0] phase;
    logic       phase_change;
    logic [1:0] pending;
    logic [7:0] ticks_left;

    logic       b_reset, b_tick, b_req_v, b_req_z;
    logic [2:0] b_phase;
    logic       b_phase_change;
    logic [1:0] b_pending;
    logic [7:0] b_ticks_left;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .req_v        (req_v),
        .req_z        (req_z),
        .phase        (phase),
        .phase_change (phase_change),
        .pending      (pending),
        .ticks_left   (ticks_left)
    );

    traffic_phase_scheduler #(
        .MAIN_GREEN_MIN (2),
        .SIDE_GREEN     (2),
        .TURN_GREEN     (2),
        .YELLOW         (1),
        .ALL_RED        (1),
        .TW             (8)
    ) dut_fast (
        .clk          (clk),
        .reset        (b_reset),
        .tick         (b_tick),
        .req_v        (b_req_v),
        .req_z        (b_req_z),
        .phase        (b_phase),
        .phase_change (b_phase_change),
        .pending      (b_pending),
        .ticks_left   (b_ticks_left)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic v, input logic z);
        tick  = t;
        req_v = v;
        req_z = z;
        @(posedge clk);
        #1;
    endtask

    task automatic stay_ticks(input int n, input logic [2:0] p, input logic v, input logic z);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, v, z);
            checkOutput("stay_phase", 8'(phase), 8'(p));
            checkOutput("stay_change", 8'(phase_change), 8'd0);
            applyStimulus(1'b0, v, z);
            checkOutput("stay_idle_phase", 8'(phase), 8'(p));
        end
    endtask

    task automatic run_phase(input logic [2:0] p, input int n, input logic [1:0] pend,
                             input logic v, input logic z);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, v, z);
            checkOutput("run_phase", 8'(phase), 8'(p));
            checkOutput("run_change", 8'(phase_change), (i == 0) ? 8'd1 : 8'd0);
            checkOutput("run_ticks_left", ticks_left, 8'(n - 1 - i));
            if (i == 0) checkOutput("run_entry_pending", 8'(pending), 8'(pend));
            applyStimulus(1'b0, v, z);
            checkOutput("run_idle_phase", 8'(phase), 8'(p));
            checkOutput("run_idle_change", 8'(phase_change), 8'd0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("reset_phase", 8'(phase), 8'd0);
        checkOutput("reset_ticks_left", ticks_left, 8'd7);
        checkOutput("reset_pending", 8'(pending), 8'd0);
        checkOutput("reset_change", 8'(phase_change), 8'd0);
    endtask

    logic [2:0] b_exp [16];

    initial begin
        reset   = 1'b1;
        tick    = 1'b0;
        req_v   = 1'b0;
        req_z   = 1'b0;
        b_reset = 1'b1;
        b_tick  = 1'b0;
        b_req_v = 1'b0;
        b_req_z = 1'b0;
        b_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0,
                  3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd6, 3'd7, 3'd0};
        $display("[TB] start");

        // Idle: no requests, main green forever, counter parks at zero.
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("idle_phase", 8'(phase), 8'd0);
            checkOutput("idle_change", 8'(phase_change), 8'd0);
            checkOutput("idle_ticks_left", ticks_left, (k < 7) ? 8'(7 - k) : 8'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("no_tick_hold", ticks_left, 8'd0);

        // Side request pulse after the second tick.
        do_reset();
        stay_ticks(2, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("side_pending_set", 8'(pending), 8'd1);
        stay_ticks(5, 3'd0, 1'b0, 1'b0);
        run_phase(3'd1, 3, 2'b01, 1'b0, 1'b0);
        run_phase(3'd2, 1, 2'b01, 1'b0, 1'b0);
        run_phase(3'd3, 1, 2'b01, 1'b0, 1'b0);
        run_phase(3'd4, 6, 2'b00, 1'b0, 1'b0);
        run_phase(3'd5, 3, 2'b00, 1'b0, 1'b0);
        run_phase(3'd0, 8, 2'b00, 1'b0, 1'b0);

        // Turn-only request pulse.
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("turn_pending_set", 8'(pending), 8'd2);
        stay_ticks(7, 3'd0, 1'b0, 1'b0);
        checkOutput("turn_pending_held", 8'(pending), 8'd2);
        run_phase(3'd1, 3, 2'b10, 1'b0, 1'b0);
        run_phase(3'd2, 1, 2'b10, 1'b0, 1'b0);
        run_phase(3'd3, 1, 2'b10, 1'b0, 1'b0);
        run_phase(3'd6, 4, 2'b00, 1'b0, 1'b0);
        run_phase(3'd7, 3, 2'b00, 1'b0, 1'b0);
        run_phase(3'd0, 8, 2'b00, 1'b0, 1'b0);

        // Contention: both sensors held, greens alternate side/turn.
        do_reset();
        stay_ticks(7, 3'd0, 1'b1, 1'b1);
        checkOutput("cont_pending_both", 8'(pending), 8'd3);
        for (int r = 0; r < 4; r++) begin
            run_phase(3'd1, 3, 2'b11, 1'b1, 1'b1);
            run_phase(3'd2, 1, 2'b11, 1'b1, 1'b1);
            run_phase(3'd3, 1, 2'b11, 1'b1, 1'b1);
            if (r % 2 == 0) begin
                run_phase(3'd4, 6, 2'b10, 1'b1, 1'b1);
                run_phase(3'd5, 3, 2'b10, 1'b1, 1'b1);
                run_phase(3'd0, 8, 2'b10, 1'b1, 1'b1);
            end else begin
                run_phase(3'd6, 4, 2'b01, 1'b1, 1'b1);
                run_phase(3'd7, 3, 2'b01, 1'b1, 1'b1);
                run_phase(3'd0, 8, 2'b01, 1'b1, 1'b1);
            end
        end

        // Reset during side green with a turn request latched.
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        stay_ticks(7, 3'd0, 1'b0, 1'b0);
        run_phase(3'd1, 3, 2'b01, 1'b0, 1'b0);
        run_phase(3'd2, 1, 2'b01, 1'b0, 1'b0);
        run_phase(3'd3, 1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("mid_phase_side", 8'(phase), 8'd4);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mid_pending_turn", 8'(pending), 8'd2);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        checkOutput("mid_reset_phase", 8'(phase), 8'd0);
        checkOutput("mid_reset_pending", 8'(pending), 8'd0);
        checkOutput("mid_reset_ticks_left", ticks_left, 8'd7);
        checkOutput("mid_reset_change", 8'(phase_change), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_decrement", ticks_left, 8'd6);
        checkOutput("post_reset_phase", 8'(phase), 8'd0);

        // Overridden durations with tick held high: dwell in clocks equals the parameter.
        checkOutput("fast_reset_phase", 8'(b_phase), 8'd0);
        checkOutput("fast_reset_ticks_left", b_ticks_left, 8'd1);
        b_reset = 1'b0;
        b_tick  = 1'b1;
        b_req_v = 1'b1;
        b_req_z = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            checkOutput("fast_phase", 8'(b_phase), 8'(b_exp[c]));
        end
        b_tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
